// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: situation codes,
// directory state encoding, CDB field widths and arbiter FSM states.
package cdb_pkg;

    localparam int CDB_W  = 22;
    localparam int SIT_W  = 6;
    localparam int DATA_W = 16;

    localparam logic [SIT_W-1:0] SIT_WR_MISS = 6'b000000;
    localparam logic [SIT_W-1:0] SIT_RD_MISS = 6'b000001;
    localparam logic [SIT_W-1:0] SIT_INVAL   = 6'b000100;
    localparam logic [SIT_W-1:0] SIT_DATA_WB = 6'b000101;
    localparam logic [SIT_W-1:0] SIT_FETCH   = 6'b100111;

    typedef enum logic [1:0] {
        DIR_U = 2'b00,
        DIR_S = 2'b01,
        DIR_E = 2'b10
    } dir_state_e;

    typedef struct packed {
        logic [SIT_W-1:0]  sit;
        logic [DATA_W-1:0] data;
    } cdb_msg_t;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    function automatic logic sit_is_legal(input logic [SIT_W-1:0] sit);
        return (sit == SIT_WR_MISS) || (sit == SIT_RD_MISS) || (sit == SIT_INVAL) ||
               (sit == SIT_DATA_WB) || (sit == SIT_FETCH);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after rr,
// wrapping modulo NREQ; eligibility is req AND mask.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] winner_oh,
    output logic [IDW-1:0]  winner_idx,
    output logic            any_win
);

    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  scan_idx;

    assign eligible = req & mask;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any_win    = 1'b0;
        scan_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx = IDW'((32'(rr) + 32'(off)) % 32'(NREQ));
            if (!any_win && eligible[scan_idx]) begin
                any_win             = 1'b1;
                winner_oh[scan_idx] = 1'b1;
                winner_idx          = scan_idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the 22-bit common data bus; each winner's message is held
// for HOLD_CYCLES cycles. Optional macro CDB_WB_PRIORITY_EN favours data write-backs.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CDB_W-1:0] msg_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    output logic [IDW-1:0]        grant_id,
    output logic [CDB_W-1:0]      cdb,
    output logic                  cdb_valid,
    output logic                  illegal_op
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             state_q,     state_d;
    logic [IDW-1:0]   rr_q,        rr_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [NREQ-1:0]  grant_q,     grant_d;
    logic [IDW-1:0]   grant_id_q,  grant_id_d;
    logic [CDB_W-1:0] cdb_q,       cdb_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [NREQ-1:0]  ack_q,       ack_d;
    logic             illegal_q,   illegal_d;

    logic [NREQ-1:0]  rr_oh;
    logic [IDW-1:0]   rr_idx;
    logic             rr_any;
    logic [NREQ-1:0]  pick_oh;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    cdb_msg_t         pick_msg;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req        (req),
        .rr         (rr_q),
        .mask       ({NREQ{1'b1}}),
        .winner_oh  (rr_oh),
        .winner_idx (rr_idx),
        .any_win    (rr_any)
    );

`ifdef CDB_WB_PRIORITY_EN
    logic [NREQ-1:0] wb_mask;
    logic [NREQ-1:0] wb_oh;
    logic [IDW-1:0]  wb_idx;
    logic            wb_any;

    always_comb begin
        wb_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            wb_mask[i] = (msg_in[i*CDB_W+DATA_W +: SIT_W] == SIT_DATA_WB);
        end
    end

    // A second pass restricted to write-backs; it overrides the plain pick when it finds one.
    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_wb_pick (
        .req        (req),
        .rr         (rr_q),
        .mask       (wb_mask),
        .winner_oh  (wb_oh),
        .winner_idx (wb_idx),
        .any_win    (wb_any)
    );

    assign pick_oh  = wb_any ? wb_oh  : rr_oh;
    assign pick_idx = wb_any ? wb_idx : rr_idx;
    assign pick_any = rr_any;
`else
    assign pick_oh  = rr_oh;
    assign pick_idx = rr_idx;
    assign pick_any = rr_any;
`endif

    always_comb begin
        pick_msg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                pick_msg = msg_in[i*CDB_W +: CDB_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        cdb_d       = cdb_q;
        cdb_valid_d = cdb_valid_q;
        ack_d       = '0;
        illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cdb_valid_d = 1'b0;
                grant_d     = '0;
                if (pick_any) begin
                    state_d     = ST_BUSY;
                    hold_cnt_d  = '0;
                    grant_d     = pick_oh;
                    grant_id_d  = pick_idx;
                    cdb_d       = pick_msg;
                    cdb_valid_d = 1'b1;
                    rr_d        = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    illegal_d   = !sit_is_legal(pick_msg.sit);
                    // Outputs are registered, so a one-cycle hold must ack on this edge already.
                    if (HOLD_LAST == '0) begin
                        ack_d = pick_oh;
                    end
                end
            end
            default: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_IDLE;
                    cdb_valid_d = 1'b0;
                    grant_d     = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_d == HOLD_LAST) begin
                        ack_d = grant_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            hold_cnt_q  <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            ack_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            ack_q       <= ack_d;
            illegal_q   <= illegal_d;
        end
    end

    assign ack        = ack_q;
    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign cdb        = cdb_q;
    assign cdb_valid  = cdb_valid_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: two instances (HOLD_CYCLES 1 and 3) checked every cycle
// against a broadcast-level model, plus directed literal expectations.
module tb_cdb_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req1, req3;
    logic [87:0] msg1, msg3;
    logic [3:0]  ack1, grant1, ack3, grant3;
    logic [1:0]  gid1, gid3;
    logic [21:0] cdb1, cdb3;
    logic        valid1, valid3, ill1, ill3;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    int          mLeft[2];
    int          mOwner[2];
    int          mRr[2];
    logic [21:0] mMsg[2];
    bit          mStart[2];

    cdb_arbiter #(.NREQ(4), .HOLD_CYCLES(1)) dutHold1 (
        .clock(clock), .reset(reset), .req(req1), .msg_in(msg1),
        .ack(ack1), .grant(grant1), .grant_id(gid1), .cdb(cdb1),
        .cdb_valid(valid1), .illegal_op(ill1)
    );

    cdb_arbiter #(.NREQ(4), .HOLD_CYCLES(3)) dutHold3 (
        .clock(clock), .reset(reset), .req(req3), .msg_in(msg3),
        .ack(ack3), .grant(grant3), .grant_id(gid3), .cdb(cdb3),
        .cdb_valid(valid3), .illegal_op(ill3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [21:0] mk(input logic [5:0] sit, input logic [15:0] data);
        return {sit, data};
    endfunction

    function automatic bit legalSit(input logic [5:0] sit);
        return sit inside {6'b000000, 6'b000001, 6'b000100, 6'b000101, 6'b100111};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [3:0] r, input logic [87:0] m);
        if (k == 0) begin
            req1 = r;
            msg1 = m;
        end else begin
            req3 = r;
            msg3 = m;
        end
    endtask

    // Model: a broadcast occupies the bus for `hold` cycles; a new winner is chosen
    // only on an edge where no broadcast was in progress.
    task automatic modelStep(input int k, input logic [3:0] r, input logic [87:0] m);
        int pick;
        int idx;
        int hold;
        hold = (k == 0) ? 1 : 3;
        mStart[k] = 0;
        if (reset) begin
            mLeft[k] = 0; mOwner[k] = 0; mRr[k] = 0; mMsg[k] = '0;
            return;
        end
        if (mLeft[k] > 0) begin
            mLeft[k]--;
            return;
        end
        pick = -1;
`ifdef CDB_WB_PRIORITY_EN
        for (int n = 0; n < 4; n++) begin
            idx = (mRr[k] + n) % 4;
            if (pick < 0 && r[idx] && m[idx*22+16 +: 6] == 6'b000101) pick = idx;
        end
`endif
        for (int n = 0; n < 4; n++) begin
            idx = (mRr[k] + n) % 4;
            if (pick < 0 && r[idx]) pick = idx;
        end
        if (pick >= 0) begin
            mOwner[k] = pick;
            mMsg[k]   = m[pick*22 +: 22];
            mLeft[k]  = hold;
            mRr[k]    = (pick + 1) % 4;
            mStart[k] = 1;
        end
    endtask

    always @(posedge clock) begin
        modelStep(0, req1, msg1);
        modelStep(1, req3, msg3);
    end

    task automatic cmpInst(input int k, input logic [3:0] a, input logic [3:0] g, input logic [1:0] id,
                           input logic [21:0] c, input logic v, input logic il);
        bit ev;
        string p;
        ev = (mLeft[k] > 0);
        p = (k == 0) ? "h1" : "h3";
        checkOutput({p, " cdb_valid"}, 32'(v), 32'(ev));
        checkOutput({p, " grant"}, 32'(g), ev ? 32'(1 << mOwner[k]) : 32'd0);
        checkOutput({p, " ack"}, 32'(a), (mLeft[k] == 1) ? 32'(1 << mOwner[k]) : 32'd0);
        checkOutput({p, " cdb"}, 32'(c), 32'(mMsg[k]));
        checkOutput({p, " illegal_op"}, 32'(il), 32'(mStart[k] && !legalSit(mMsg[k][21:16])));
        if (ev) checkOutput({p, " grant_id"}, 32'(id), 32'(mOwner[k]));
    endtask

    always @(negedge clock) begin
        if (checking) begin
            cmpInst(0, ack1, grant1, gid1, cdb1, valid1, ill1);
            cmpInst(1, ack3, grant3, gid3, cdb3, valid3, ill3);
        end
    end

    int expGid[5] = '{0, 1, 2, 3, 0};
    logic [3:0] expAck3[4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [3:0] reqPat[8] = '{4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b1000, 4'b0101, 4'b1100, 4'b0011};
    logic [5:0] sitPat[6] = '{6'b000000, 6'b000001, 6'b010101, 6'b000100, 6'b000101, 6'b100111};

    initial begin
        int firstWin;
        logic [87:0] m;
        reset = 1'b1;
        applyStimulus(0, 4'b1111, {mk(6'b000001, 16'h1003), mk(6'b000001, 16'h1002),
                                   mk(6'b000001, 16'h1001), mk(6'b000001, 16'h1000)});
        applyStimulus(1, 4'b0000, '0);
        @(negedge clock);
        checking = 1;

        // Reset held with all requests raised
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset valid", 32'(valid1), 32'd0);
            checkOutput("reset grant", 32'(grant1), 32'd0);
            checkOutput("reset ack", 32'(ack1), 32'd0);
            checkOutput("reset cdb", 32'(cdb1), 32'd0);
            @(negedge clock);
        end
        reset = 1'b0;

        // Continuous requests, one-cycle hold: grants 0,1,2,3,0 every other cycle
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            checkOutput("rr valid", 32'(valid1), 32'(k % 2));
            if (k % 2 == 1) begin
                checkOutput("rr grant_id", 32'(gid1), 32'(expGid[(k-1)/2]));
                checkOutput("rr ack", 32'(ack1), 32'(1 << expGid[(k-1)/2]));
            end
            if (k == 1) checkOutput("first cdb", 32'(cdb1), 32'h011000);
        end
        req1 = 4'b0000;
        repeat (2) @(negedge clock);

        // Three-cycle hold, requester drops req after first busy cycle
        applyStimulus(1, 4'b0100, {22'd0, mk(6'b000001, 16'hBEEF), 22'd0, 22'd0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k == 0) req3 = 4'b0000;
            checkOutput("hold3 valid", 32'(valid3), (k < 3) ? 32'd1 : 32'd0);
            checkOutput("hold3 cdb", 32'(cdb3), 32'h01BEEF);
            checkOutput("hold3 ack", 32'(ack3), 32'(expAck3[k]));
        end

        // Illegal situation code still broadcast, flagged once
        applyStimulus(0, 4'b0010, {22'd0, 22'd0, mk(6'b111000, 16'h1234), 22'd0});
        @(negedge clock);
        req1 = 4'b0000;
        checkOutput("illegal pulse", 32'(ill1), 32'd1);
        checkOutput("illegal cdb", 32'(cdb1), 32'h381234);
        checkOutput("illegal grant_id", 32'(gid1), 32'd1);
        @(negedge clock);
        checkOutput("illegal once", 32'(ill1), 32'd0);
        repeat (2) @(negedge clock);

        // Reset in the middle of a three-cycle broadcast
        applyStimulus(1, 4'b1111, {mk(6'b100111, 16'h3003), mk(6'b100111, 16'h3002),
                                   mk(6'b100111, 16'h3001), mk(6'b100111, 16'h3000)});
        @(negedge clock);
        checkOutput("abort pre grant_id", 32'(gid3), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort valid", 32'(valid3), 32'd0);
        checkOutput("abort ack", 32'(ack3), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort rr restart", 32'(gid3), 32'd0);
        checkOutput("abort new cdb", 32'(cdb3), 32'h273000);
        req3 = 4'b0000;
        repeat (4) @(negedge clock);

        // Read miss on 0, write-back on 1; winner drops after its ack
`ifdef CDB_WB_PRIORITY_EN
        firstWin = 1;
`else
        firstWin = 0;
`endif
        applyStimulus(0, 4'b0011, {22'd0, 22'd0, mk(6'b000101, 16'hBBBB), mk(6'b000001, 16'hAAAA)});
        @(negedge clock);
        checkOutput("wb first grant_id", 32'(gid1), 32'(firstWin));
        req1 = req1 & ~4'(1 << firstWin);
        repeat (2) @(negedge clock);
        checkOutput("wb second grant_id", 32'(gid1), 32'(1 - firstWin));
        req1 = 4'b0000;
        repeat (2) @(negedge clock);

        // Table-driven mixed traffic, checked by the model each cycle
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 4; i++) begin
                m[i*22 +: 22] = mk(sitPat[(s + i) % 6], 16'(s * 16 + i));
            end
            applyStimulus(0, reqPat[s % 8], m);
            applyStimulus(1, reqPat[(s + 3) % 8], ~m);
            @(negedge clock);
        end
        applyStimulus(0, 4'b0000, '0);
        applyStimulus(1, 4'b0000, '0);
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
